// File: rtl/usb_bulk_in_ep_buf_if.sv
// Purpose : bundles the application write port and the controller transmit port of a bulk-IN buffer.
// Latency : n/a (signal bundle only).
// Backpressure: full_o refuses writes; txcork_o tells the controller to NAK.
// Ports   : master = application/controller side, slave = buffer side.
interface usb_bulk_in_ep_buf_if #(
    parameter int DEPTH_LOG2 = 10
);
    // application write side
    logic                  flush_i;
    logic                  highspeed_i;
    logic [7:0]            wr_dat_i;
    logic                  wr_en_i;
    logic                  full_o;
    logic                  wr_ovf_o;
    logic [DEPTH_LOG2:0]   level_o;
    // controller transmit side
    logic [3:0]            endpt_i;
    logic                  txact_i;
    logic                  txpop_i;
    logic                  txpktfin_i;
    logic [7:0]            txdat_o;
    logic [11:0]           txdat_len_o;
    logic                  txcork_o;

    modport master (
        output flush_i, highspeed_i, wr_dat_i, wr_en_i,
        output endpt_i, txact_i, txpop_i, txpktfin_i,
        input  full_o, wr_ovf_o, level_o,
        input  txdat_o, txdat_len_o, txcork_o
    );

    modport slave (
        input  flush_i, highspeed_i, wr_dat_i, wr_en_i,
        input  endpt_i, txact_i, txpop_i, txpktfin_i,
        output full_o, wr_ovf_o, level_o,
        output txdat_o, txdat_len_o, txcork_o
    );
endinterface

// File: rtl/usb_bulk_in_ep_buf.sv
// Purpose : bulk-IN endpoint packet buffer; bytes are freed only when the host ACKs, so retries resend them.
// Latency : written byte counts in level_o next cycle; txdat_o follows a pop by one cycle.
// Backpressure: writes while full are dropped (wr_ovf_o pulse); txcork_o=1 makes the controller NAK.
// Ports   : clk_i (60 MHz UTMI), reset_i (async, active-high), bus (usb_bulk_in_ep_buf_if.slave).
module usb_bulk_in_ep_buf #(
    parameter logic [3:0] EP_NUM     = 4'd2,
    parameter int         DEPTH_LOG2 = 10,
    parameter int         HS_MPS     = 512,
    parameter int         FS_MPS     = 64
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    usb_bulk_in_ep_buf_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [7:0]    mem [DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr, sp_ptr, sp_end;
    logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt, sp_ptr_nxt;
    logic [PW-1:0] level, lvl_nxt;
    logic [1:0]    state, state_nxt;
    logic          committed, committed_nxt;
    logic          txact_q;
    logic          full, wr_acc, sel, act_rise, act_fall;
    logic [11:0]   mps, nxt_len;
    logic [7:0]    txdat;
    logic [11:0]   txdat_len;
    logic          txcork;
    logic          wr_ovf;

    assign level    = wr_ptr - rd_ptr;
    assign full     = (level == PW'(DEPTH));
    assign wr_acc   = bus.wr_en_i && !full && !bus.flush_i;
    assign sel      = (bus.endpt_i == EP_NUM);
    assign act_rise = bus.txact_i && !txact_q;
    assign act_fall = !bus.txact_i && txact_q;
    assign mps      = bus.highspeed_i ? 12'(HS_MPS) : 12'(FS_MPS);

    always_comb begin
        wr_ptr_nxt    = wr_ptr;
        rd_ptr_nxt    = rd_ptr;
        sp_ptr_nxt    = sp_ptr;
        state_nxt     = state;
        committed_nxt = committed;
        if (wr_acc)
            wr_ptr_nxt = wr_ptr + 1'b1;
        if (bus.flush_i) begin
            wr_ptr_nxt    = '0;
            rd_ptr_nxt    = '0;
            state_nxt     = ST_IDLE;
            committed_nxt = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (act_rise && sel) begin
                        state_nxt     = ST_SEND;
                        committed_nxt = 1'b0;
                    end
                end
                ST_SEND: begin
                    // sp_end caps the pops at the frozen packet length
                    if (bus.txpop_i && sp_ptr != sp_end)
                        sp_ptr_nxt = sp_ptr + 1'b1;
                    // an ACK can arrive before txact drops; commit once, leave on the fall
                    if (bus.txpktfin_i && !committed) begin
                        rd_ptr_nxt    = sp_end;
                        committed_nxt = 1'b1;
                    end
                    if (act_fall)
                        state_nxt = committed_nxt ? ST_IDLE : ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.txpktfin_i) begin
                        rd_ptr_nxt = sp_end;
                        state_nxt  = ST_IDLE;
                    end else if (act_rise && sel) begin
                        // host retry: resend the same bytes, sp_end is unchanged
                        sp_ptr_nxt = rd_ptr;
                        state_nxt  = ST_SEND;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
        // while idle the send pointer shadows the committed read pointer
        if (state_nxt == ST_IDLE)
            sp_ptr_nxt = rd_ptr_nxt;
    end

    // offered length/cork are computed from post-update pointers so they never
    // advertise bytes that a same-cycle commit or flush just removed
    always_comb begin
        lvl_nxt = wr_ptr_nxt - rd_ptr_nxt;
        nxt_len = mps;
        if (12'(lvl_nxt) < mps)
            nxt_len = 12'(lvl_nxt);
    end

    always_ff @(posedge clk_i) begin
        if (wr_acc)
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= bus.wr_dat_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            sp_ptr    <= '0;
            sp_end    <= '0;
            state     <= ST_IDLE;
            committed <= 1'b0;
            txact_q   <= 1'b0;
            txdat     <= 8'd0;
            txdat_len <= 12'd0;
            txcork    <= 1'b1;
            wr_ovf    <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            sp_ptr    <= sp_ptr_nxt;
            state     <= state_nxt;
            committed <= committed_nxt;
            txact_q   <= bus.txact_i;
            wr_ovf    <= bus.wr_en_i && full;
            // read address is the next send pointer so a pop shows its successor next cycle
            txdat     <= mem[sp_ptr_nxt[DEPTH_LOG2-1:0]];
            if (state == ST_IDLE && state_nxt == ST_SEND)
                sp_end <= rd_ptr + PW'(txdat_len);
            // length and cork freeze for the whole SEND/HOLD episode
            if (state_nxt == ST_IDLE) begin
                txdat_len <= nxt_len;
                txcork    <= (lvl_nxt == '0);
            end
        end
    end

    assign bus.full_o      = full;
    assign bus.wr_ovf_o    = wr_ovf;
    assign bus.level_o     = level;
    assign bus.txdat_o     = txdat;
    assign bus.txdat_len_o = txdat_len;
    assign bus.txcork_o    = txcork;
endmodule

// File: tb/tb_usb_bulk_in_ep_buf.sv
// Purpose : directed self-checking bench for the bulk-IN endpoint buffer.
// Latency : inputs driven and outputs sampled on the falling clock edge.
// Backpressure: exercises full/overflow, NAK cork, retry and flush.
module tb_usb_bulk_in_ep_buf;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   wcnt  = 0;

    always #5 clk = ~clk;

    usb_bulk_in_ep_buf_if #(.DEPTH_LOG2(10)) bus ();

    usb_bulk_in_ep_buf #(
        .EP_NUM(4'd2), .DEPTH_LOG2(10), .HS_MPS(512), .FS_MPS(64)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    task automatic do_reset(input logic hs);
        rst             = 1'b1;
        bus.flush_i     = 1'b0;
        bus.highspeed_i = hs;
        bus.wr_dat_i    = 8'd0;
        bus.wr_en_i     = 1'b0;
        bus.endpt_i     = 4'd2;
        bus.txact_i     = 1'b0;
        bus.txpop_i     = 1'b0;
        bus.txpktfin_i  = 1'b0;
        wcnt            = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // bytes carry the low 8 bits of a running write index
    task automatic write_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            bus.wr_en_i  = 1'b1;
            bus.wr_dat_i = 8'(wcnt);
            wcnt++;
            @(negedge clk);
        end
        bus.wr_en_i = 1'b0;
    endtask

    // one IN transaction: n pops checking bytes first..first+n-1, optional ACK
    task automatic in_txn(input int n, input int first, input bit fin);
        logic [7:0] exp;
        bus.txact_i = 1'b1;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            exp = 8'(first + i);
            total++;
            if (bus.txdat_o !== exp) begin
                bad++;
                $display("FAIL txdat byte %0d: got %02h expected %02h", i, bus.txdat_o, exp);
            end
            bus.txpop_i = 1'b1;
            @(negedge clk);
        end
        bus.txpop_i = 1'b0;
        bus.txact_i = 1'b0;
        @(negedge clk);
        if (fin) begin
            bus.txpktfin_i = 1'b1;
            @(negedge clk);
            bus.txpktfin_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total += 6;
        if (bus.txcork_o !== 1'b1) begin bad++; $display("FAIL reset txcork: got %b expected 1", bus.txcork_o); end
        if (bus.txdat_len_o !== 12'd0) begin bad++; $display("FAIL reset txdat_len: got %0d expected 0", bus.txdat_len_o); end
        if (bus.txdat_o !== 8'd0) begin bad++; $display("FAIL reset txdat: got %02h expected 00", bus.txdat_o); end
        if (bus.full_o !== 1'b0) begin bad++; $display("FAIL reset full: got %b expected 0", bus.full_o); end
        if (bus.wr_ovf_o !== 1'b0) begin bad++; $display("FAIL reset wr_ovf: got %b expected 0", bus.wr_ovf_o); end
        if (bus.level_o !== 11'd0) begin bad++; $display("FAIL reset level: got %0d expected 0", bus.level_o); end
    endtask

    task automatic test_basic();
        do_reset(1'b1);
        write_bytes(10);
        @(negedge clk);
        total += 2;
        if (bus.txcork_o !== 1'b0) begin bad++; $display("FAIL basic cork: got %b expected 0", bus.txcork_o); end
        if (bus.txdat_len_o !== 12'd10) begin bad++; $display("FAIL basic len: got %0d expected 10", bus.txdat_len_o); end
        in_txn(10, 0, 1'b1);
        total += 2;
        if (bus.level_o !== 11'd0) begin bad++; $display("FAIL basic level after ack: got %0d expected 0", bus.level_o); end
        if (bus.txcork_o !== 1'b1) begin bad++; $display("FAIL basic cork after ack: got %b expected 1", bus.txcork_o); end
    endtask

    task automatic test_mps();
        int exp_len;
        do_reset(1'b1);
        write_bytes(600);
        total++;
        if (bus.txdat_len_o !== 12'd512) begin bad++; $display("FAIL hs first len: got %0d expected 512", bus.txdat_len_o); end
        in_txn(512, 0, 1'b1);
        total += 2;
        if (bus.txdat_len_o !== 12'd88) begin bad++; $display("FAIL hs second len: got %0d expected 88", bus.txdat_len_o); end
        if (bus.level_o !== 11'd88) begin bad++; $display("FAIL hs level: got %0d expected 88", bus.level_o); end

        do_reset(1'b0);
        write_bytes(600);
        for (int k = 0; k < 10; k++) begin
            exp_len = (k < 9) ? 64 : 24;
            total++;
            if (bus.txdat_len_o !== 12'(exp_len)) begin
                bad++;
                $display("FAIL fs len pkt %0d: got %0d expected %0d", k, bus.txdat_len_o, exp_len);
            end
            in_txn(exp_len, k * 64, 1'b1);
        end
        total++;
        if (bus.level_o !== 11'd0) begin bad++; $display("FAIL fs final level: got %0d expected 0", bus.level_o); end
    endtask

    task automatic test_retry();
        do_reset(1'b1);
        write_bytes(20);
        in_txn(20, 0, 1'b0);
        total++;
        if (bus.level_o !== 11'd20) begin bad++; $display("FAIL retry level after nak: got %0d expected 20", bus.level_o); end
        in_txn(20, 0, 1'b0);
        total += 2;
        if (bus.level_o !== 11'd20) begin bad++; $display("FAIL retry level after resend: got %0d expected 20", bus.level_o); end
        if (bus.txdat_len_o !== 12'd20) begin bad++; $display("FAIL retry len frozen: got %0d expected 20", bus.txdat_len_o); end
        // ACK lands together with a new write: 20 + 1 - 20
        bus.txpktfin_i = 1'b1;
        bus.wr_en_i    = 1'b1;
        bus.wr_dat_i   = 8'h55;
        @(negedge clk);
        bus.txpktfin_i = 1'b0;
        bus.wr_en_i    = 1'b0;
        total += 2;
        if (bus.level_o !== 11'd1) begin bad++; $display("FAIL ack+write level: got %0d expected 1", bus.level_o); end
        if (bus.txdat_len_o !== 12'd1) begin bad++; $display("FAIL ack+write len: got %0d expected 1", bus.txdat_len_o); end
    endtask

    task automatic test_full();
        do_reset(1'b1);
        write_bytes(1024);
        total += 2;
        if (bus.full_o !== 1'b1) begin bad++; $display("FAIL full flag: got %b expected 1", bus.full_o); end
        if (bus.level_o !== 11'd1024) begin bad++; $display("FAIL full level: got %0d expected 1024", bus.level_o); end
        bus.wr_en_i  = 1'b1;
        bus.wr_dat_i = 8'hAA;
        @(negedge clk);
        bus.wr_en_i = 1'b0;
        total += 2;
        if (bus.wr_ovf_o !== 1'b1) begin bad++; $display("FAIL ovf pulse: got %b expected 1", bus.wr_ovf_o); end
        if (bus.level_o !== 11'd1024) begin bad++; $display("FAIL ovf level: got %0d expected 1024", bus.level_o); end
        @(negedge clk);
        total++;
        if (bus.wr_ovf_o !== 1'b0) begin bad++; $display("FAIL ovf single: got %b expected 0", bus.wr_ovf_o); end
        in_txn(512, 0, 1'b1);
        total += 2;
        if (bus.full_o !== 1'b0) begin bad++; $display("FAIL full after ack: got %b expected 0", bus.full_o); end
        if (bus.level_o !== 11'd512) begin bad++; $display("FAIL level after ack: got %0d expected 512", bus.level_o); end
    endtask

    task automatic test_wrap();
        do_reset(1'b1);
        write_bytes(1000);
        in_txn(512, 0, 1'b1);
        in_txn(488, 512, 1'b1);
        write_bytes(100);
        total++;
        if (bus.txdat_len_o !== 12'd100) begin bad++; $display("FAIL wrap len: got %0d expected 100", bus.txdat_len_o); end
        in_txn(100, 1000, 1'b1);
        total++;
        if (bus.level_o !== 11'd0) begin bad++; $display("FAIL wrap level: got %0d expected 0", bus.level_o); end
    endtask

    task automatic test_flush();
        do_reset(1'b1);
        write_bytes(300);
        total++;
        if (bus.txdat_len_o !== 12'd300) begin bad++; $display("FAIL flush pre len: got %0d expected 300", bus.txdat_len_o); end
        bus.txact_i = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bus.txpop_i = 1'b1;
            @(negedge clk);
        end
        bus.txpop_i  = 1'b0;
        bus.flush_i  = 1'b1;
        bus.wr_en_i  = 1'b1;
        bus.wr_dat_i = 8'h77;
        @(negedge clk);
        bus.flush_i = 1'b0;
        bus.wr_en_i = 1'b0;
        total += 2;
        if (bus.level_o !== 11'd0) begin bad++; $display("FAIL flush level: got %0d expected 0", bus.level_o); end
        if (bus.txcork_o !== 1'b1) begin bad++; $display("FAIL flush cork: got %b expected 1", bus.txcork_o); end
        bus.txact_i = 1'b0;
        @(negedge clk);
        bus.txpktfin_i = 1'b1;
        @(negedge clk);
        bus.txpktfin_i = 1'b0;
        @(negedge clk);
        total += 2;
        if (bus.level_o !== 11'd0) begin bad++; $display("FAIL late ack level: got %0d expected 0", bus.level_o); end
        if (bus.txcork_o !== 1'b1) begin bad++; $display("FAIL late ack cork: got %b expected 1", bus.txcork_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mps();
        test_retry();
        test_full();
        test_wrap();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
